pow2_scan: RTL and testbench

//   Sequential, parametrised power-of-two detector. Accepts one W-bit word over a

---
 rtl/pow2_scan.sv | 126 ++++++++++++
 tb/tb_pow2_scan.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow2_scan.sv
// pow2_scan: sequential power-of-two detector.
// Accepts one W-bit word over a valid/ready handshake and scans it CHUNK bits
// per cycle, LSB chunk first. It reports whether exactly one bit is set, the
// index of that bit, and whether the word was all zeros.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   x carries a word
//   in_ready   out  block can accept a word (IDLE only)
//   x          in   W-bit word under test, x[0] is index 0
//   out_valid  out  result registers hold a completed result
//   out_ready  in   consumer takes the result
//   is_pow2    out  exactly one bit of the word was set
//   idx        out  index of that bit when is_pow2, else 0
//   zero       out  word was all zeros
module pow2_scan #(
  parameter  int W     = 8,
  parameter  int CHUNK = 2,
  localparam int IW    = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          is_pow2,
  output logic [IW-1:0] idx,
  output logic          zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    sreg;
  logic [1:0]      cnt;      // saturating set-bit count: 0, 1, or 2 (= many)
  logic [IW-1:0]   base;     // bit index of sreg[0] within the original word
  logic [IW-1:0]   rec_idx;  // index of the first set bit seen so far

  logic [CHUNK-1:0] chunk;
  logic [1:0]       p_sat;
  logic [IW-1:0]    pos;
  logic [2:0]       cnt_sum;
  logic [1:0]       cnt_nxt;
  logic             hit_first;
  logic             last;
  logic             finish;
  logic [IW-1:0]    idx_first;

  always_comb begin
    chunk = sreg[CHUNK-1:0];
    p_sat = '0;
    pos   = '0;
    // pos is only consumed when the chunk holds exactly one set bit
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        pos = IW'(i);
        if (p_sat != 2'd2) p_sat = p_sat + 2'd1;
      end
    end
    cnt_sum   = {1'b0, cnt} + {1'b0, p_sat};
    cnt_nxt   = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
    hit_first = (cnt == 2'd0) && (p_sat == 2'd1);
    idx_first = base + pos;
    last      = (base == IW'(W - CHUNK));
    finish    = (cnt_nxt == 2'd2) || last;
  end

  always_comb begin
    in_ready = (state == IDLE) && !reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      base      <= '0;
      rec_idx   <= '0;
      out_valid <= 1'b0;
      is_pow2   <= 1'b0;
      idx       <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= x;
            cnt     <= '0;
            base    <= '0;
            rec_idx <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          cnt  <= cnt_nxt;
          sreg <= sreg >> CHUNK;
          base <= base + IW'(CHUNK);
          if (hit_first) rec_idx <= idx_first;
          if (finish) begin
            // the index found on this very edge is not yet in rec_idx
            state     <= DONE;
            out_valid <= 1'b1;
            is_pow2   <= (cnt_nxt == 2'd1);
            zero      <= (cnt_nxt == 2'd0);
            idx       <= (cnt_nxt == 2'd1) ? (hit_first ? idx_first : rec_idx) : '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow2_scan.sv
// tb_pow2_scan: self-checking bench for pow2_scan.
// Main instance W=8/CHUNK=2 runs a vector table plus backpressure and
// mid-scan reset sequences; further instances sweep CHUNK and W=16 against a
// popcount/log2 reference model.
module tb_pow2_scan;

  typedef struct {
    logic p;
    int   idx;
    logic z;
    int   lat;
  } res_t;

  typedef struct {
    logic [7:0] x;
    res_t       r;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  // ---------------- main instance W=8, CHUNK=2 ----------------
  logic       in_valid, in_ready, out_valid, out_ready, is_pow2, zero;
  logic [7:0] x;
  logic [2:0] idx;

  pow2_scan #(.W(8), .CHUNK(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .is_pow2  (is_pow2),
    .idx      (idx),
    .zero     (zero)
  );

  res_t sb[$];

  // Entered and left at posedge+1 with the DUT idle and out_ready high.
  task automatic run_word(input logic [7:0] xv, input res_t e);
    int   cyc;
    res_t r;
    sb.push_back(e);
    chk($sformatf("in_ready_pre x=%h", xv), int'(in_ready), 1);
    x = xv;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    r = sb.pop_front();
    chk($sformatf("latency x=%h", xv), cyc, r.lat);
    chk($sformatf("is_pow2 x=%h", xv), int'(is_pow2), int'(r.p));
    chk($sformatf("idx x=%h", xv), int'(idx), r.idx);
    chk($sformatf("zero x=%h", xv), int'(zero), int'(r.z));
    @(posedge clock); #1;
  endtask

  // ---------------- parameter sweep instances ----------------
  logic [4:0] start_sweep = 1'b0 ? 5'd0 : 5'd0;
  logic       go = 1'b0;
  logic [4:0] done;

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int GW = (g == 4) ? 16 : 8;
    localparam int GC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
    localparam int GI = $clog2(GW);

    logic          iv, ir, ov, ordy, p, z;
    logic [GW-1:0] xx;
    logic [GI-1:0] id;
    res_t          q[$];

    pow2_scan #(.W(GW), .CHUNK(GC)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (iv),
      .in_ready (ir),
      .x        (xx),
      .out_valid(ov),
      .out_ready(ordy),
      .is_pow2  (p),
      .idx      (id),
      .zero     (z)
    );

    function automatic res_t model(input logic [GW-1:0] v);
      res_t m;
      int   c;
      c     = 0;
      m.idx = 0;
      m.lat = GW / GC;
      for (int b = 0; b < GW; b++) begin
        if (v[b]) begin
          c++;
          if (c == 1) m.idx = b;
          if (c == 2) m.lat = b / GC + 1;
        end
      end
      m.p = (c == 1);
      m.z = (c == 0);
      if (!m.p) m.idx = 0;
      return m;
    endfunction

    initial begin
      int          cyc;
      int unsigned nwords;
      res_t        r;
      logic [GW-1:0] v;
      iv   = 1'b0;
      ordy = 1'b1;
      xx   = '0;
      done[g] = 1'b0;
      wait (go);
      @(posedge clock); #1;
      nwords = (GW == 8) ? 256 : 300;
      for (int unsigned n = 0; n < nwords; n++) begin
        if (GW == 8) v = GW'(n);
        else if (n % 3 == 0) v = GW'(1) << $urandom_range(GW - 1);
        else if (n % 3 == 1) v = (GW'(1) << $urandom_range(GW - 1)) | (GW'(1) << $urandom_range(GW - 1));
        else v = GW'($urandom);
        q.push_back(model(v));
        cyc = 0;
        while (!ir && cyc < 20) begin
          @(posedge clock); #1;
          cyc++;
        end
        xx = v;
        iv = 1'b1;
        @(posedge clock); #1;
        iv = 1'b0;
        cyc = 0;
        while (!ov && cyc < 3 * GW) begin
          @(posedge clock); #1;
          cyc++;
        end
        r = q.pop_front();
        if (r.lat != cyc || r.p != p || r.idx != int'(id) || r.z != z) begin
          chk($sformatf("w%0dc%0d_lat x=%h", GW, GC, v), cyc, r.lat);
          chk($sformatf("w%0dc%0d_pow2 x=%h", GW, GC, v), int'(p), int'(r.p));
          chk($sformatf("w%0dc%0d_idx x=%h", GW, GC, v), int'(id), r.idx);
          chk($sformatf("w%0dc%0d_zero x=%h", GW, GC, v), int'(z), int'(r.z));
        end else begin
          chk($sformatf("w%0dc%0d_word x=%h", GW, GC, v), int'(id), r.idx);
        end
        @(posedge clock); #1;
      end
      done[g] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  vec_t vecs[12];

  initial begin
    int cyc;
    vecs[0]  = '{8'h01, '{1'b1, 0, 1'b0, 4}};
    vecs[1]  = '{8'h80, '{1'b1, 7, 1'b0, 4}};
    vecs[2]  = '{8'h10, '{1'b1, 4, 1'b0, 4}};
    vecs[3]  = '{8'h03, '{1'b0, 0, 1'b0, 1}};
    vecs[4]  = '{8'h81, '{1'b0, 0, 1'b0, 4}};
    vecs[5]  = '{8'h00, '{1'b0, 0, 1'b1, 4}};
    vecs[6]  = '{8'h0C, '{1'b0, 0, 1'b0, 2}};
    vecs[7]  = '{8'h04, '{1'b1, 2, 1'b0, 4}};
    vecs[8]  = '{8'h05, '{1'b0, 0, 1'b0, 2}};
    vecs[9]  = '{8'h41, '{1'b0, 0, 1'b0, 4}};
    vecs[10] = '{8'hFF, '{1'b0, 0, 1'b0, 1}};
    vecs[11] = '{8'h20, '{1'b1, 5, 1'b0, 4}};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_is_pow2", int'(is_pow2), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_zero", int'(zero), 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 12; i++) run_word(vecs[i].x, vecs[i].r);

    // backpressure: hold the result for 5 cycles while in_valid toggles
    out_ready = 1'b0;
    x = 8'h08;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("bp_latency", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      x = 8'hFF;
      chk($sformatf("bp_out_valid c%0d", i), int'(out_valid), 1);
      chk($sformatf("bp_in_ready c%0d", i), int'(in_ready), 0);
      chk($sformatf("bp_is_pow2 c%0d", i), int'(is_pow2), 1);
      chk($sformatf("bp_idx c%0d", i), int'(idx), 3);
      chk($sformatf("bp_zero c%0d", i), int'(zero), 0);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);
    run_word(8'h02, '{1'b1, 1, 1'b0, 4});

    // reset in the middle of a scan
    x = 8'h40;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_is_pow2", int'(is_pow2), 0);
    chk("midrst_idx", int'(idx), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid_after", int'(out_valid), 0);
    @(posedge clock); #1;
    run_word(8'h40, '{1'b1, 6, 1'b0, 4});

    // parameter sweep runs on the other instances
    go = 1'b1;
    cyc = 0;
    while (done != 5'h1F && cyc < 40000) begin
      @(posedge clock);
      cyc++;
    end
    chk("sweep_finished", int'(done == 5'h1F), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
